// File: rtl/data_mem_arbiter.sv
// Two-port round-robin arbiter in front of one data memory.
// Bad requests are answered locally; stuck accesses abort after TIMEOUT cycles.
module data_mem_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        P0_Read,
    input  logic        P0_Write,
    input  logic [31:0] P0_Address,
    input  logic [31:0] P0_Write_data,
    input  logic [2:0]  P0_Func3,
    output logic [31:0] P0_Read_data,
    output logic        P0_Ack,
    output logic        P0_Err,
    output logic        P0_busywait,
    input  logic        P1_Read,
    input  logic        P1_Write,
    input  logic [31:0] P1_Address,
    input  logic [31:0] P1_Write_data,
    input  logic [2:0]  P1_Func3,
    output logic [31:0] P1_Read_data,
    output logic        P1_Ack,
    output logic        P1_Err,
    output logic        P1_busywait,
    output logic        Mem_Read,
    output logic        Mem_Write,
    output logic [31:0] Mem_Address,
    output logic [31:0] Mem_Write_data,
    output logic [2:0]  Mem_Func3,
    input  logic [31:0] Mem_Read_data,
    input  logic        Mem_busywait
);
    typedef enum logic [1:0] { IDLE, ACCESS, RESP } state_t;
    localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

    state_t      state_q;
    logic [7:0]  cnt_q;
    logic        last_q, gnt_q, rd_q, wr_q;
    logic [31:0] addr_q, wdata_q, rdata0_q, rdata1_q;
    logic [2:0]  f3_q;
    logic        ack0_q, ack1_q, err0_q, err1_q;

    logic        req0, req1, pick, grant;
    logic        s_rd, s_wr, illegal, misalign;
    logic [31:0] s_addr, s_wdata;
    logic [2:0]  s_f3;
    logic        resp_go, resp_port, resp_err;
    logic [31:0] resp_data;

    assign req0  = P0_Read | P0_Write;
    assign req1  = P1_Read | P1_Write;
    assign pick  = (req0 & req1) ? ~last_q : req1;
    assign grant = (state_q == IDLE) & (req0 | req1);

    assign s_rd    = pick ? P1_Read       : P0_Read;
    assign s_wr    = pick ? P1_Write      : P0_Write;
    assign s_addr  = pick ? P1_Address    : P0_Address;
    assign s_wdata = pick ? P1_Write_data : P0_Write_data;
    assign s_f3    = pick ? P1_Func3      : P0_Func3;

    always_comb begin
        illegal = s_rd & s_wr;
        if (s_rd && !(s_f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101}))
            illegal = 1'b1;
        if (s_wr && !(s_f3 inside {3'b000, 3'b001, 3'b010}))
            illegal = 1'b1;
    end

    always_comb begin
        misalign = 1'b0;
        unique case (s_f3[1:0])
            2'b01:   misalign = s_addr[0];
            2'b10:   misalign = |s_addr[1:0];
            default: misalign = 1'b0;
        endcase
    end

    // One response path shared by local errors, completions and timeouts.
    always_comb begin
        resp_go   = 1'b0;
        resp_port = gnt_q;
        resp_err  = 1'b0;
        resp_data = '0;
        unique case (state_q)
            IDLE: begin
                resp_go   = grant & (illegal | misalign);
                resp_port = pick;
                resp_err  = 1'b1;
            end
            ACCESS: begin
                resp_go   = ~Mem_busywait | (cnt_q == CntLast);
                resp_err  = Mem_busywait;
                resp_data = (rd_q & ~Mem_busywait) ? Mem_Read_data : '0;
            end
            default: resp_go = 1'b0;
        endcase
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            last_q   <= 1'b1;
            gnt_q    <= 1'b0;
            rd_q     <= 1'b0;
            wr_q     <= 1'b0;
            addr_q   <= '0;
            wdata_q  <= '0;
            f3_q     <= '0;
            rdata0_q <= '0;
            rdata1_q <= '0;
            ack0_q   <= 1'b0;
            ack1_q   <= 1'b0;
            err0_q   <= 1'b0;
            err1_q   <= 1'b0;
        end else begin
            ack0_q <= 1'b0;
            ack1_q <= 1'b0;
            err0_q <= 1'b0;
            err1_q <= 1'b0;
            unique case (state_q)
                IDLE: begin
                    if (grant) begin
                        gnt_q  <= pick;
                        last_q <= pick;
                        rd_q   <= s_rd;
                        wr_q   <= s_wr;
                        cnt_q  <= '0;
                        if (illegal | misalign) begin
                            state_q <= RESP;
                        end else begin
                            state_q <= ACCESS;
                            addr_q  <= s_addr;
                            wdata_q <= s_wdata;
                            f3_q    <= s_f3;
                        end
                    end
                end
                ACCESS: begin
                    if (resp_go) state_q <= RESP;
                    else         cnt_q   <= cnt_q + 8'd1;
                end
                default: state_q <= IDLE;
            endcase
            if (resp_go) begin
                if (resp_port) begin
                    ack1_q   <= 1'b1;
                    err1_q   <= resp_err;
                    rdata1_q <= resp_data;
                end else begin
                    ack0_q   <= 1'b1;
                    err0_q   <= resp_err;
                    rdata0_q <= resp_data;
                end
            end
        end
    end

    // Address/data/func3 only change on legal grants, so they hold outside ACCESS.
    assign Mem_Read       = (state_q == ACCESS) & rd_q;
    assign Mem_Write      = (state_q == ACCESS) & wr_q;
    assign Mem_Address    = addr_q;
    assign Mem_Write_data = wdata_q;
    assign Mem_Func3      = f3_q;

    assign P0_Read_data = rdata0_q;
    assign P0_Ack       = ack0_q;
    assign P0_Err       = err0_q;
    assign P0_busywait  = req0 & ~ack0_q;
    assign P1_Read_data = rdata1_q;
    assign P1_Ack       = ack1_q;
    assign P1_Err       = err1_q;
    assign P1_busywait  = req1 & ~ack1_q;
endmodule

// File: doc/data_mem_arbiter.md
DATA_MEM_ARBITER -- requirements
Module: data_mem_arbiter

Interface
REQ-001 Parameter: TIMEOUT, default 255, maximum ACCESS cycles before abort (range 2..255).
REQ-002 Clock  in  1  single clock; all state updates on rising edge.
REQ-003 Reset  in  1  asynchronous, active-low reset.
REQ-004 P0_Read, P0_Write  in  1 each  pipeline MEM-stage request (port 0).
REQ-005 P0_Address, P0_Write_data  in  32 each; P0_Func3  in  3  RV32 load/store width code.
REQ-006 P0_Read_data  out  32; P0_Ack, P0_Err, P0_busywait  out  1 each.
REQ-007 P1_*  same set and widths as P0_*, for the loader/debug requester (port 1).
REQ-008 Mem_Read, Mem_Write  out  1; Mem_Address, Mem_Write_data  out  32; Mem_Func3  out  3.
REQ-009 Mem_Read_data  in  32; Mem_busywait  in  1, high while the memory access is pending.

Function
REQ-010 Request on port n is Pn_Read|Pn_Write; it is held stable by the requester until Pn_Ack.
REQ-011 Pn_busywait is combinational: (Pn_Read|Pn_Write) & ~Pn_Ack.
REQ-012 The state machine has states IDLE, ACCESS and RESP; reset state is IDLE.
REQ-013 In IDLE, arbitration samples requests at each rising edge.
REQ-014 Single requester: grant it. Both requesting: grant the port not granted last (round-robin).
REQ-015 After reset, last_grant = 1, so port 0 wins the first contention.
REQ-016 On grant, latch Read, Write, Address, Write_data, Func3 and the grant index into registers.
REQ-017 Illegal request: Read&Write both high, read Func3 not in {000,001,010,100,101}, or write Func3 not in {000,001,010}.
REQ-018 Misaligned request: halfword with Address[0]=1, or word with Address[1:0]!=0.
REQ-019 Illegal or misaligned grant: go to RESP directly with Err=1 and Read_data=0; no Mem_Read/Mem_Write is asserted.
REQ-020 Legal grant: go to ACCESS; Mem_* outputs are driven from the latched registers only while in ACCESS.
REQ-021 Outside ACCESS, Mem_Read=Mem_Write=0; Mem_Address, Mem_Write_data and Mem_Func3 hold their last values.
REQ-022 ACCESS, rising edge with Mem_busywait=0: capture Mem_Read_data (reads only, else 0) and go to RESP with Err=0.
REQ-023 ACCESS cycle counter starts at 0 on entry and increments each edge while Mem_busywait=1.
REQ-024 If the counter reaches TIMEOUT-1 with Mem_busywait still 1: go to RESP with Err=1, Read_data=0, and drop the memory strobes.
REQ-025 RESP lasts exactly one cycle; the granted port's Pn_Ack=1 and Pn_Err is valid in that cycle; next state is IDLE.
REQ-026 In RESP, Pn_Read_data is valid on the granted port; it holds until that port's next RESP.
REQ-027 Non-granted port outputs Ack=0 and Err=0; no requests are sampled in ACCESS or RESP.
REQ-028 Minimum latency with memory ready: request sampled at edge k, Mem strobe in cycle k..k+1, Ack in cycle k+1..k+2.
REQ-029 Requests dropped before Ack are protocol violations; the in-flight access still completes and Ack still pulses.
REQ-030 last_grant updates at the grant edge, including for illegal or misaligned grants.

Reset
REQ-031 Reset low immediately forces: state IDLE, counter 0, last_grant 1, and all outputs 0.
REQ-032 Outputs forced to 0 include Mem_* outputs, Pn_Read_data, Pn_Ack and Pn_Err; Pn_busywait follows REQ-011.
REQ-033 Reset asserted mid-ACCESS aborts the access with no Ack; operation resumes on the first rising edge after reset deasserts.

Verification
REQ-034 P0 LW at 0x10, Mem_busywait low, Mem_Read_data=0xDEADBEEF -> one ACCESS cycle; P0_Ack pulses one cycle later; P0_Read_data=0xDEADBEEF, P0_Err=0.
REQ-035 P0 and P1 SW requests on the same edge, three times -> grants P0,P1,P0; each access lasts one ACCESS cycle; no overlapping Acks.
REQ-036 P1 LH at 0x13 -> no Mem_Read; P1_Ack with P1_Err=1, P1_Read_data=0. P0 Func3=011 read -> same error response.
REQ-037 Mem_busywait held high, TIMEOUT=4 -> exactly 4 ACCESS cycles, then Ack with Err=1; Mem_Read drops in the RESP cycle.
REQ-038 Reset pulsed during the 2nd cycle of a 5-cycle busywait access -> Mem_Read=0 immediately, no Ack; re-request after release gives a normal 2-cycle completion.
